seven_segment_scanner: RTL and testbench
========================================

# seven_segment_scanner

Time-multiplexing controller for the board's 4-digit common-anode 7-segment display. It holds a 4-character word of raw segment patterns and drives one digit at a time. Each digit gets a programmable on-time, preceded by a blanking gap that suppresses ghosting. New words arrive through a valid/ready handshake and are applied only at frame boundaries, so a word never tears mid-scan. It sits between user logic (letter/counter generators) and the top-level `abcdefgh`/`digit` pins.

## Interface

Parameters:
- `DIGIT_CYCLES`, 50000, clock cycles each digit is lit (≥1; 1 ms at 50 MHz).
- `BLANK_CYCLES`, 500, clock cycles all digits are dark before each digit (≥1).

Ports:
- `clk` input 1: the block's single clock; all logic is on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `enable` input 1: scanning on when high; display dark when low.
- `load_valid` input 1: `load_data` is offered.
- `load_ready` output 1: the pending buffer can accept a word.
- `load_data` input 32: four active-low segment patterns, `[7:0]` = digit 0 (rightmost) … `[31:24]` = digit 3.
- `abcdefgh` output 8: active-low segments, a in bit 7, h (dot) in bit 0.
- `digit` output 4: active-low digit select; `4'b1110` = digit 0.
- `frame_done` output 1: one-cycle pulse at the end of each complete 4-digit frame.

## Operation

- Storage:
  - `active` word (32 bits): the word being displayed.
  - `pending` word (32 bits) plus a `pending_full` flag.
  - 2-bit digit index `idx`.
  - Phase counter sized `$clog2(max(DIGIT_CYCLES, BLANK_CYCLES))`.
- FSM states: IDLE, BLANK, SHOW.
  - IDLE → BLANK: when `enable`=1; sets `idx`=0 and clears the counter.
  - BLANK → SHOW: after exactly `BLANK_CYCLES` cycles in BLANK.
  - SHOW → BLANK: after exactly `DIGIT_CYCLES` cycles in SHOW; `idx` increments.
  - When leaving SHOW at `idx`=3, `idx` wraps to 0 and the frame is complete.
  - Any state → IDLE: when `enable`=0 is sampled. The mid-frame position is discarded; the next enable restarts at BLANK, digit 0.
- Outputs per state:
  - IDLE and BLANK: `abcdefgh`=8'hFF, `digit`=4'hF.
  - SHOW: `abcdefgh`=`active[8*idx+:8]`, `digit`=`~(4'b0001<<idx)`.
- Handshake:
  - `load_ready` = `!pending_full`.
  - A transfer occurs when `load_valid && load_ready` at a clock edge; it captures `load_data` into `pending` and sets `pending_full`.
  - `load_data` is ignored when no transfer occurs.
- Commit (`pending` → `active`, clears `pending_full`):
  - At the edge ending SHOW of digit 3.
  - On any edge where the state is IDLE.
  - A transfer and a commit in the same cycle cannot both involve new data: ready was low, so the commit takes the previously held word.
- `frame_done`: high for exactly the last cycle of SHOW at `idx`=3.
- Reset values:
  - State IDLE, `idx`=0, counter 0.
  - `active`=32'hFFFF_FFFF, `pending_full`=0, `pending`=32'hFFFF_FFFF.
  - Outputs: `abcdefgh`=8'hFF, `digit`=4'hF, `frame_done`=0, `load_ready`=1.
- `reset` has priority over `enable` and the handshake.

## Timing

- `abcdefgh`, `digit` and `frame_done` are registers updated on the same edge as the state, so pins change exactly at phase boundaries.
- Frame length = 4·(`BLANK_CYCLES`+`DIGIT_CYCLES`) cycles.
- First lit cycle of digit 0 = `BLANK_CYCLES`+1 cycles after the edge that samples `enable`=1 in IDLE.
- A word transferred during frame N is first shown at digit 0 of frame N+1. A word loaded in IDLE is shown on the first SHOW after enable.
- `load_ready` falls the cycle after a transfer. It rises the cycle after the commit.
- Never two digit-select bits low; never segments low while `digit`=4'hF.

## Structure

- Shared package `seven_segment_pkg`:
  - Letter constants (C=8'b01100011, E=8'b01100001, h=8'b11010001, I=8'b11110011, P=8'b00110001).
  - `SEG_OFF`=8'hFF and `DIGIT_OFF`=4'hF.
  - FSM state typedef.
- Single module, no sub-modules; the counter and FSM are small enough to live inline.

## Test plan

All scenarios use `DIGIT_CYCLES`=4 and `BLANK_CYCLES`=2, giving a 24-cycle frame.

1. Reset, then `enable`=0 for 10 cycles → `abcdefgh`=FF, `digit`=F, `load_ready`=1, `frame_done`=0 throughout.
2. Load 32'h31F3D163 (P,I,h,C) in IDLE, then raise `enable` → repeating pattern of 2 dark cycles then 4 cycles per digit: 1110/63, 1101/D1, 1011/F3, 0111/31. `frame_done` pulses once every 24 cycles, on the last 0111 cycle.
3. Load 32'h61616161 at the 3rd SHOW cycle of digit 1 → digits 2 and 3 still show the old word. Next frame, digit 0 shows 61. `load_ready`=0 from the cycle after the transfer until the cycle after the commit.
4. Hold `load_valid` high with a different word while `pending_full` → no second transfer until after the commit. Exactly one word is committed per frame.
5. Drop `enable` during SHOW of digit 2 → dark on the next cycle. On re-enable, the scan restarts with BLANK then digit 0, and `frame_done` does not pulse for the aborted frame.
6. Assert `reset` mid-SHOW with `pending_full`=1 → next cycle all outputs are at reset values, `load_ready`=1, and `active` shows all off after re-enable.

Source files
------------

// File: rtl/seven_segment_pkg.sv
// Shared definitions for the 4-digit 7-segment display scanner.
// Segment patterns are active-low, a in bit 7 down to h (dot) in bit 0.
package seven_segment_pkg;

  // Letter glyphs for user logic driving the scanner
  localparam logic [7:0] SEG_C = 8'b01100011;
  localparam logic [7:0] SEG_E = 8'b01100001;
  localparam logic [7:0] SEG_H = 8'b11010001;
  localparam logic [7:0] SEG_I = 8'b11110011;
  localparam logic [7:0] SEG_P = 8'b00110001;

  // All segments dark / no digit selected
  localparam logic [7:0] SEG_OFF   = 8'hFF;
  localparam logic [3:0] DIGIT_OFF = 4'hF;

  typedef enum logic [1:0] {
    StIdle,
    StBlank,
    StShow
  } scan_state_e;

  function automatic int unsigned max_cycles(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// Each digit is preceded by an all-dark gap, then lit for a fixed on-time.
// New words are accepted into a one-deep pending buffer and only become
// visible at a frame boundary (or immediately while idle), so a word never
// tears mid-scan.
//
// Ports:
//   clk        - clock, all logic on rising edge
//   reset      - synchronous active-high reset
//   enable     - scan when high, display dark when low
//   load_valid - load_data offered
//   load_ready - pending buffer empty, can accept a word
//   load_data  - four active-low patterns, [7:0] = digit 0 (rightmost)
//   abcdefgh   - active-low segments (registered)
//   digit      - active-low digit select, 4'b1110 = digit 0 (registered)
//   frame_done - pulse during the last lit cycle of digit 3 (registered)
module seven_segment_scanner
  import seven_segment_pkg::*;
#(
  parameter int unsigned DIGIT_CYCLES = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_data,
  output logic [7:0]  abcdefgh,
  output logic [3:0]  digit,
  output logic        frame_done
);

  localparam int unsigned MaxCycles = max_cycles(DIGIT_CYCLES, BLANK_CYCLES);
  // Keep at least one bit so 1-cycle phases still synthesize a counter
  localparam int unsigned CntW = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
  localparam logic [CntW-1:0] DigitLast = CntW'(DIGIT_CYCLES - 1);
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);

  scan_state_e     state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     active_q, active_d;
  logic [31:0]     pending_q, pending_d;
  logic            pending_full_q, pending_full_d;
  logic [7:0]      seg_q, seg_d;
  logic [3:0]      dig_q, dig_d;
  logic            fd_q, fd_d;
  logic            commit;
  logic            transfer;

  assign load_ready = !pending_full_q;
  assign abcdefgh   = seg_q;
  assign digit      = dig_q;
  assign frame_done = fd_q;

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    cnt_d          = cnt_q;
    active_d       = active_q;
    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    commit         = 1'b0;
    transfer       = load_valid && !pending_full_q;

    unique case (state_q)
      StIdle: begin
        // Nothing on screen, so a held word can be promoted at once
        commit = 1'b1;
        if (enable) begin
          state_d = StBlank;
          idx_d   = 2'd0;
          cnt_d   = '0;
        end
      end
      StBlank: begin
        if (cnt_q == BlankLast) begin
          state_d = StShow;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StShow: begin
        if (cnt_q == DigitLast) begin
          state_d = StBlank;
          cnt_d   = '0;
          idx_d   = idx_q + 2'd1;
          commit  = (idx_q == 2'd3);
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        idx_d   = 2'd0;
        cnt_d   = '0;
      end
    endcase

    // Dropping enable discards the frame position from any state
    if (!enable) begin
      state_d = StIdle;
      idx_d   = 2'd0;
      cnt_d   = '0;
    end

    if (commit && pending_full_q) begin
      active_d       = pending_q;
      pending_full_d = 1'b0;
    end
    // transfer only happens when pending was empty, so it never races a commit
    if (transfer) begin
      pending_d      = load_data;
      pending_full_d = 1'b1;
    end

    // Outputs are registered from next-state so pins change on phase edges
    seg_d = SEG_OFF;
    dig_d = DIGIT_OFF;
    fd_d  = 1'b0;
    if (state_d == StShow) begin
      seg_d = active_q[{idx_d, 3'b000} +: 8];
      dig_d = ~(4'b0001 << idx_d);
      fd_d  = (idx_d == 2'd3) && (cnt_d == DigitLast);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      idx_q          <= 2'd0;
      cnt_q          <= '0;
      active_q       <= 32'hFFFF_FFFF;
      pending_q      <= 32'hFFFF_FFFF;
      pending_full_q <= 1'b0;
      seg_q          <= SEG_OFF;
      dig_q          <= DIGIT_OFF;
      fd_q           <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      cnt_q          <= cnt_d;
      active_q       <= active_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      seg_q          <= seg_d;
      dig_q          <= dig_d;
      fd_q           <= fd_d;
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed bench for seven_segment_scanner with DIGIT_CYCLES=4, BLANK_CYCLES=2
// (24-cycle frame). Expected pin values are queued per cycle as stimulus is
// applied and popped one per clock once the DUT has updated.
module tb_seven_segment_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_data;
  logic [7:0]  abcdefgh;
  logic [3:0]  digit;
  logic        frame_done;

  always #5 clk = ~clk;

  seven_segment_scanner #(
    .DIGIT_CYCLES(4),
    .BLANK_CYCLES(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_data (load_data),
    .abcdefgh  (abcdefgh),
    .digit     (digit),
    .frame_done(frame_done)
  );

  typedef struct packed {
    logic [7:0] seg;
    logic [3:0] dig;
    logic       fd;
  } exp_t;

  exp_t sb[$];

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  // Behavioural view of the display contract
  logic        m_run       = 1'b0;
  int          pos         = 0;
  logic [31:0] m_active    = 32'hFFFF_FFFF;
  logic [31:0] m_pend      = 32'hFFFF_FFFF;
  logic        m_pend_full = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s at %0t: observed %h expected %h", tag, $time, obs, exp);
    end
  endtask

  task automatic push_dark();
    exp_t e;
    e.seg = 8'hFF;
    e.dig = 4'hF;
    e.fd  = 1'b0;
    sb.push_back(e);
  endtask

  // One full frame: per digit two dark cycles then four lit cycles
  task automatic push_frame(input logic [31:0] w);
    exp_t e;
    logic [3:0] one;
    one = 4'b0001;
    for (int d = 0; d < 4; d++) begin
      for (int k = 0; k < 6; k++) begin
        if (k < 2) begin
          push_dark();
        end else begin
          e.seg = w[8*d +: 8];
          e.dig = ~(one << d);
          e.fd  = (d == 3) && (k == 5);
          sb.push_back(e);
        end
      end
    end
  endtask

  // Apply one clock edge with the currently driven inputs, then check pins
  task automatic step();
    exp_t e;
    logic commit;
    logic xfer;
    if (reset) begin
      m_run       = 1'b0;
      pos         = 0;
      m_active    = 32'hFFFF_FFFF;
      m_pend      = 32'hFFFF_FFFF;
      m_pend_full = 1'b0;
      sb.delete();
    end else begin
      commit = m_pend_full && (!m_run || pos == 23);
      xfer   = load_valid && !m_pend_full;
      if (commit) begin
        m_active    = m_pend;
        m_pend_full = 1'b0;
      end
      if (xfer) begin
        m_pend      = load_data;
        m_pend_full = 1'b1;
      end
      if (!enable) begin
        if (m_run) sb.delete();
        m_run = 1'b0;
      end else if (!m_run) begin
        m_run = 1'b1;
        pos   = 0;
        push_frame(m_active);
      end else begin
        pos = (pos + 1) % 24;
        if (pos == 0) push_frame(m_active);
      end
    end
    if (!m_run) push_dark();

    @(posedge clk);
    #1;

    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL scoreboard at %0t: observed empty queue expected entry", $time);
    end else begin
      e = sb.pop_front();
      chk("abcdefgh", {24'h0, abcdefgh}, {24'h0, e.seg});
      chk("digit", {28'h0, digit}, {28'h0, e.dig});
      chk("frame_done", {31'h0, frame_done}, {31'h0, e.fd});
    end
    chk("load_ready", {31'h0, load_ready}, {31'h0, !m_pend_full});
  endtask

  initial begin
    reset      = 1'b1;
    enable     = 1'b0;
    load_valid = 1'b0;
    load_data  = 32'h0;

    // Reset, then idle with enable low
    repeat (2) step();
    reset = 1'b0;
    repeat (10) step();

    // Load P,I,h,C while idle, then scan two frames
    load_valid = 1'b1;
    load_data  = 32'h31F3_D163;
    step();
    load_valid = 1'b0;
    load_data  = 32'hDEAD_BEEF;
    step();
    step();
    enable = 1'b1;
    repeat (48) step();

    // Mid-frame load at the 3rd lit cycle of digit 1
    repeat (11) step();
    load_valid = 1'b1;
    load_data  = 32'h6161_6161;
    step();
    load_valid = 1'b0;
    repeat (12) step();
    repeat (24) step();

    // Hold valid with a second word while pending is full
    repeat (11) step();
    load_valid = 1'b1;
    load_data  = 32'h6363_3131;
    step();
    load_data  = 32'hF3D1_61F3;
    repeat (13) step();
    step();
    load_valid = 1'b0;
    repeat (22) step();
    repeat (24) step();

    // Drop enable while digit 2 is lit, then restart
    repeat (16) step();
    enable = 1'b0;
    repeat (6) step();
    enable = 1'b1;
    repeat (24) step();

    // Reset mid-show with a word pending
    repeat (3) step();
    load_valid = 1'b1;
    load_data  = 32'h3131_3131;
    step();
    load_valid = 1'b0;
    repeat (5) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (24) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
